// File: rtl/lc4_issue_ss.sv
// lc4_issue_ss: two-slot decode/issue buffer for the two-pipe LC4 core.
// Holds up to two decoded packets in program order, and each cycle issues
// 0, 1 or 2 of them into pipes A and B. It also drives the register-file read
// selectors and refills its slots from fetch.
// Optional build macro LC4_ISSUE_STATS_EN adds three 16-bit saturating
// issue-statistics counters as extra output ports.
module lc4_issue_ss #(
   parameter int PKT_W = 47
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             gwe,
   input  logic             i_f_valid_0,
   input  logic [PKT_W-1:0] i_f_pkt_0,
   input  logic             i_f_valid_1,
   input  logic [PKT_W-1:0] i_f_pkt_1,
   output logic [1:0]       o_f_take,
   input  logic             i_flush,
   input  logic             i_x_load_A,
   input  logic [2:0]       i_x_rd_A,
   input  logic             i_x_load_B,
   input  logic [2:0]       i_x_rd_B,
   output logic             o_issue_A,
   output logic [PKT_W-1:0] o_pkt_A,
   output logic             o_issue_B,
   output logic [PKT_W-1:0] o_pkt_B,
   output logic [2:0]       o_rs_A,
   output logic [2:0]       o_rt_A,
   output logic [2:0]       o_rs_B,
   output logic [2:0]       o_rt_B
`ifdef LC4_ISSUE_STATS_EN
   ,
   output logic [15:0]      o_cnt_dual,
   output logic [15:0]      o_cnt_split,
   output logic [15:0]      o_cnt_stall
`endif
);

   // Decoded packet layout, MSB first (47 bits total).
   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] insn;
      logic [2:0]  rs;
      logic        rs_re;
      logic [2:0]  rt;
      logic        rt_re;
      logic [2:0]  rd;
      logic        rd_we;
      logic        is_mem;
      logic        is_load;
      logic        is_ctrl;
   } pkt_t;

   pkt_t       slot0_q, slot0_d, slot1_q, slot1_d;
   logic       v0_q, v0_d, v1_q, v1_d;
   logic       lu0, lu1, raw_pair, mem_pair, issue_a, issue_b;
   logic [1:0] n_rem, n_free, n_fetch, take;

   // A slot must wait if either X-stage load writes a register it reads.
   function automatic logic load_use(input pkt_t p,
                                     input logic la, input logic [2:0] ra,
                                     input logic lb, input logic [2:0] rb);
      logic hit_a, hit_b;
      hit_a = la && ((p.rs_re && p.rs == ra) || (p.rt_re && p.rt == ra));
      hit_b = lb && ((p.rs_re && p.rs == rb) || (p.rt_re && p.rt == rb));
      return hit_a || hit_b;
   endfunction

   // Hazard detection and the issue decision for both pipes.
   always_comb begin
      lu0      = load_use(slot0_q, i_x_load_A, i_x_rd_A, i_x_load_B, i_x_rd_B);
      lu1      = load_use(slot1_q, i_x_load_A, i_x_rd_A, i_x_load_B, i_x_rd_B);
      raw_pair = slot0_q.rd_we &&
                 ((slot1_q.rs_re && slot1_q.rs == slot0_q.rd) ||
                  (slot1_q.rt_re && slot1_q.rt == slot0_q.rd));
      mem_pair = slot0_q.is_mem && slot1_q.is_mem;
      issue_a  = v0_q && !lu0 && !i_flush;
      // Pipe B never runs ahead of pipe A, past a branch, or into a second
      // data-memory access in the same cycle.
      issue_b  = issue_a && v1_q && !lu1 && !raw_pair && !mem_pair &&
                 !slot0_q.is_ctrl;
   end

   // Fetch handshake: take as many in-order packets as there will be free slots.
   always_comb begin
      n_rem   = {1'b0, v0_q} + {1'b0, v1_q} - {1'b0, issue_a} - {1'b0, issue_b};
      n_free  = 2'd2 - n_rem;
      n_fetch = !i_f_valid_0 ? 2'd0 : (i_f_valid_1 ? 2'd2 : 2'd1);
      take    = i_flush ? 2'd0 : ((n_free < n_fetch) ? n_free : n_fetch);
   end

   // Next slot contents: compact the surviving packet down, then refill in order.
   always_comb begin
      // NOTE: every always_comb target gets a default first so no latch is inferred.
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      v0_d    = v0_q;
      v1_d    = v1_q;
      if (i_flush) begin
         v0_d = 1'b0;
         v1_d = 1'b0;
      end else begin
         if (issue_a) begin
            if (issue_b || !v1_q) begin
               v0_d = 1'b0;
            end else begin
               slot0_d = slot1_q;   // split issue: the younger packet moves to pipe A
               v0_d    = 1'b1;
            end
            v1_d = 1'b0;
         end
         if (!v0_d) begin
            if (take != 2'd0) begin
               slot0_d = pkt_t'(i_f_pkt_0);
               v0_d    = 1'b1;
            end
            if (take == 2'd2) begin
               slot1_d = pkt_t'(i_f_pkt_1);
               v1_d    = 1'b1;
            end
         end else if (!v1_d && take != 2'd0) begin
            slot1_d = pkt_t'(i_f_pkt_0);
            v1_d    = 1'b1;
         end
      end
   end

   // Slot registers advance only on global write enable; reset clears the valid bits.
   always_ff @(posedge clk) begin
      if (gwe) begin
         // NOTE: sequential state uses non-blocking assignments only.
         if (rst) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
         end else begin
            v0_q <= v0_d;
            v1_q <= v1_d;
         end
      end
   end

   // Packet payloads: left unreset on purpose, since the valid bits mask every use.
   always_ff @(posedge clk) begin
      if (gwe && !rst) begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
      end
   end

   // Output drive: everything reads as zero for an empty slot.
   always_comb begin
      o_f_take  = take;
      o_issue_A = issue_a;
      o_issue_B = issue_b;
      o_pkt_A   = v0_q ? PKT_W'(slot0_q) : '0;
      o_pkt_B   = v1_q ? PKT_W'(slot1_q) : '0;
      o_rs_A    = v0_q ? slot0_q.rs : 3'd0;
      o_rt_A    = v0_q ? slot0_q.rt : 3'd0;
      o_rs_B    = v1_q ? slot1_q.rs : 3'd0;
      o_rt_B    = v1_q ? slot1_q.rt : 3'd0;
   end

`ifdef LC4_ISSUE_STATS_EN
   logic [15:0] cnt_dual_q, cnt_split_q, cnt_stall_q;

   // Saturating statistics counters for dual issue, split issue and stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_dual_q  <= '0;
         cnt_split_q <= '0;
         cnt_stall_q <= '0;
      end else if (gwe) begin
         if (issue_a && issue_b && cnt_dual_q != 16'hFFFF)
            cnt_dual_q <= cnt_dual_q + 16'd1;
         if (issue_a && !issue_b && v1_q && cnt_split_q != 16'hFFFF)
            cnt_split_q <= cnt_split_q + 16'd1;
         if (v0_q && !issue_a && cnt_stall_q != 16'hFFFF)
            cnt_stall_q <= cnt_stall_q + 16'd1;
      end
   end

   assign o_cnt_dual  = cnt_dual_q;
   assign o_cnt_split = cnt_split_q;
   assign o_cnt_stall = cnt_stall_q;
`endif

endmodule

// File: tb/tb_lc4_issue_ss.sv
// tb_lc4_issue_ss: directed self-checking bench for the LC4 two-slot issue buffer.
module tb_lc4_issue_ss;

   localparam int PKT_W = 47;

   logic             clk = 1'b0;
   logic             rst, gwe;
   logic             i_f_valid_0, i_f_valid_1;
   logic [PKT_W-1:0] i_f_pkt_0, i_f_pkt_1;
   logic [1:0]       o_f_take;
   logic             i_flush;
   logic             i_x_load_A, i_x_load_B;
   logic [2:0]       i_x_rd_A, i_x_rd_B;
   logic             o_issue_A, o_issue_B;
   logic [PKT_W-1:0] o_pkt_A, o_pkt_B;
   logic [2:0]       o_rs_A, o_rt_A, o_rs_B, o_rt_B;
`ifdef LC4_ISSUE_STATS_EN
   logic [15:0]      o_cnt_dual, o_cnt_split, o_cnt_stall;
   logic [15:0]      snap_dual, snap_split, snap_stall;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   lc4_issue_ss #(.PKT_W(PKT_W)) dut (
      .clk(clk), .rst(rst), .gwe(gwe),
      .i_f_valid_0(i_f_valid_0), .i_f_pkt_0(i_f_pkt_0),
      .i_f_valid_1(i_f_valid_1), .i_f_pkt_1(i_f_pkt_1),
      .o_f_take(o_f_take), .i_flush(i_flush),
      .i_x_load_A(i_x_load_A), .i_x_rd_A(i_x_rd_A),
      .i_x_load_B(i_x_load_B), .i_x_rd_B(i_x_rd_B),
      .o_issue_A(o_issue_A), .o_pkt_A(o_pkt_A),
      .o_issue_B(o_issue_B), .o_pkt_B(o_pkt_B),
      .o_rs_A(o_rs_A), .o_rt_A(o_rt_A), .o_rs_B(o_rs_B), .o_rt_B(o_rt_B)
`ifdef LC4_ISSUE_STATS_EN
      , .o_cnt_dual(o_cnt_dual), .o_cnt_split(o_cnt_split), .o_cnt_stall(o_cnt_stall)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic v0, input logic [PKT_W-1:0] p0,
                        input logic v1, input logic [PKT_W-1:0] p1);
      i_f_valid_0 = v0;
      i_f_pkt_0   = p0;
      i_f_valid_1 = v1;
      i_f_pkt_1   = p1;
   endtask

   function automatic logic [PKT_W-1:0] mk(input logic [15:0] pc, input logic [15:0] insn,
         input logic [2:0] rs, input logic rs_re, input logic [2:0] rt, input logic rt_re,
         input logic [2:0] rd, input logic rd_we,
         input logic is_mem, input logic is_load, input logic is_ctrl);
      return {pc, insn, rs, rs_re, rt, rt_re, rd, rd_we, is_mem, is_load, is_ctrl};
   endfunction

   function automatic logic [PKT_W-1:0] add(input logic [15:0] pc,
         input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
      return mk(pc, {4'b0001, rd, rs, 3'b000, rt}, rs, 1'b1, rt, 1'b1, rd, 1'b1,
                1'b0, 1'b0, 1'b0);
   endfunction

   logic [PKT_W-1:0] a0, a1, r1, z3, ld, st, br;
   logic [PKT_W-1:0] zp;

   initial begin
      zp = '0;
      a0 = add(16'h0100, 3'd1, 3'd2, 3'd3);              // ADD R1,R2,R3
      a1 = add(16'h0101, 3'd4, 3'd5, 3'd6);              // ADD R4,R5,R6
      r1 = add(16'h0102, 3'd4, 3'd1, 3'd1);              // ADD R4,R1,R1
      z3 = add(16'h0103, 3'd7, 3'd0, 3'd0);              // ADD R7,R0,R0
      ld = mk(16'h0200, {4'b0110, 3'd1, 3'd2, 6'd0}, 3'd2, 1'b1, 3'd0, 1'b0,
              3'd1, 1'b1, 1'b1, 1'b1, 1'b0);             // LDR R1,R2,#0
      st = mk(16'h0201, {4'b0111, 3'd3, 3'd4, 6'd0}, 3'd4, 1'b1, 3'd3, 1'b1,
              3'd0, 1'b0, 1'b1, 1'b0, 1'b0);             // STR R3,R4,#0
      br = mk(16'h0300, {4'b0000, 3'b100, 9'd5}, 3'd0, 1'b0, 3'd0, 1'b0,
              3'd0, 1'b0, 1'b0, 1'b0, 1'b1);             // BRn +5

      rst = 1'b1; gwe = 1'b1; i_flush = 1'b0;
      i_x_load_A = 1'b0; i_x_rd_A = 3'd0; i_x_load_B = 1'b0; i_x_rd_B = 3'd0;
      fetch(1'b0, zp, 1'b0, zp);
      step(); step();
      rst = 1'b0;
      #1;
      check("rst_issue_A", o_issue_A, 0);
      check("rst_issue_B", o_issue_B, 0);
      check("rst_pkt_A", o_pkt_A, 0);
      check("rst_pkt_B", o_pkt_B, 0);
      check("rst_sel", {o_rs_A, o_rt_A, o_rs_B, o_rt_B}, 0);
      check("rst_take", o_f_take, 0);

      // Independent pair: filled in one cycle, dual issue the next.
      fetch(1'b1, a0, 1'b1, a1); #1;
      check("fill_take", o_f_take, 2);
      check("fill_no_issue", o_issue_A, 0);
      step();
      fetch(1'b0, zp, 1'b0, zp); #1;
      check("dual_A", o_issue_A, 1);
      check("dual_B", o_issue_B, 1);
      check("dual_sel", {o_rs_A, o_rt_A, o_rs_B, o_rt_B}, {3'd2, 3'd3, 3'd5, 3'd6});
      check("dual_pkt_A", o_pkt_A, a0);
      check("dual_pkt_B", o_pkt_B, a1);
      check("dual_take_nofetch", o_f_take, 0);
      step();

      // Intra-pair RAW: split issue, younger packet moves into pipe A.
      fetch(1'b1, a0, 1'b1, r1); #1; step();
      fetch(1'b1, z3, 1'b0, zp); #1;
      check("raw_A", o_issue_A, 1);
      check("raw_B", o_issue_B, 0);
      check("raw_take", o_f_take, 1);
      step();
      fetch(1'b0, zp, 1'b0, zp); #1;
      check("raw_shift_pkt_A", o_pkt_A, r1);
      check("raw_shift_rs_A", o_rs_A, 1);
      check("raw_refill_pkt_B", o_pkt_B, z3);
      check("raw_next_dual", o_issue_B, 1);
      step();

      // Load-use on slot0 via pipe B: full stall, slots held.
      fetch(1'b1, a0, 1'b1, a1); #1; step();
      fetch(1'b0, zp, 1'b0, zp);
      i_x_load_B = 1'b1; i_x_rd_B = 3'd2; #1;
      check("lu_A", o_issue_A, 0);
      check("lu_B", o_issue_B, 0);
      check("lu_take", o_f_take, 0);
      step();
      check("lu_hold_A", o_pkt_A, a0);
      check("lu_hold_B", o_pkt_B, a1);
      i_x_load_B = 1'b0; #1;
      check("lu_clear_A", o_issue_A, 1);
      check("lu_clear_B", o_issue_B, 1);
      step();

      // Load-use on slot1 only via pipe A (slot1 reads R6).
      fetch(1'b1, a0, 1'b1, a1); #1; step();
      fetch(1'b0, zp, 1'b0, zp);
      i_x_load_A = 1'b1; i_x_rd_A = 3'd6; #1;
      check("lu1_A", o_issue_A, 1);
      check("lu1_B", o_issue_B, 0);
      step();
      i_x_load_A = 1'b0; #1;
      check("lu1_shift_pkt_A", o_pkt_A, a1);
      check("lu1_pkt_B_empty", o_pkt_B, 0);
      check("lu1_shift_issue", o_issue_A, 1);
      step();

      // Two memory ops: split issue, store follows in pipe A.
      fetch(1'b1, ld, 1'b1, st); #1; step();
      fetch(1'b0, zp, 1'b0, zp); #1;
      check("mem_A", o_issue_A, 1);
      check("mem_B", o_issue_B, 0);
      step();
      check("mem_st_pkt_A", o_pkt_A, st);
      check("mem_st_issue_A", o_issue_A, 1);
      check("mem_st_issue_B", o_issue_B, 0);
      step();

      // Control in slot0 blocks pipe B; then a flush empties both slots.
      fetch(1'b1, br, 1'b1, a1); #1; step();
      fetch(1'b1, a0, 1'b0, zp); #1;
      check("ctrl_A", o_issue_A, 1);
      check("ctrl_B", o_issue_B, 0);
      check("ctrl_take", o_f_take, 1);
      step();
      i_flush = 1'b1;
      fetch(1'b1, z3, 1'b1, r1); #1;
      check("flush_take", o_f_take, 0);
      check("flush_no_issue", {o_issue_A, o_issue_B}, 0);
      step();
      i_flush = 1'b0;
      fetch(1'b0, zp, 1'b0, zp); #1;
      check("flush_pkts", {o_pkt_A, o_pkt_B}, 0);
      check("flush_sel", {o_rs_A, o_rt_A, o_rs_B, o_rt_B}, 0);
      check("flush_issue", o_issue_A, 0);

      // gwe low for three cycles with valid fetch: nothing changes.
      fetch(1'b1, a0, 1'b0, zp); #1; step();
      fetch(1'b1, a1, 1'b1, r1);
      gwe = 1'b0;
`ifdef LC4_ISSUE_STATS_EN
      snap_dual = o_cnt_dual; snap_split = o_cnt_split; snap_stall = o_cnt_stall;
`endif
      for (int i = 0; i < 3; i++) begin
         #1;
         check("gwe0_take", o_f_take, 2);
         check("gwe0_pkt_A", o_pkt_A, a0);
         check("gwe0_pkt_B", o_pkt_B, 0);
         step();
      end
`ifdef LC4_ISSUE_STATS_EN
      check("gwe0_cnt_dual", o_cnt_dual, snap_dual);
      check("gwe0_cnt_split", o_cnt_split, snap_split);
      check("gwe0_cnt_stall", o_cnt_stall, snap_stall);
`endif
      gwe = 1'b1; #1; step();
      fetch(1'b0, zp, 1'b0, zp); #1;
      check("gwe1_pkt_A", o_pkt_A, a1);
      check("gwe1_pkt_B", o_pkt_B, r1);
      check("gwe1_dual", o_issue_B, 1);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
